// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding select, stall/bubble/flush sequencing and stall counter for the 5-stage core
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       exe_rd_addr,
  input  logic             exe_rd_we,
  input  logic             exe_is_load,
  input  logic [4:0]       ls_rd_addr,
  input  logic             ls_rd_we,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_we,
  input  logic             exe_br_taken,
  input  logic             exe_is_jump,
  input  logic             exe_mc_start,
  input  logic             exe_mc_done,
  input  logic             mem_busy,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_exe,
  output logic             stall_ls,
  output logic             bubble_exe,
  output logic             bubble_ls,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mc_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // e_data_hazard select encoding shared with the EXE operand muxes
  localparam logic [1:0] NO_HAZARD = 2'd0;
  localparam logic [1:0] FROM_EXE  = 2'd1;
  localparam logic [1:0] FROM_LS   = 2'd2;
  localparam logic [1:0] FROM_WB   = 2'd3;

  localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MC_TIMEOUT);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait;
  logic              set_err;
  logic              load_use;

  // Youngest producer wins; a load in EXE has no data yet, so it is skipped here
  // and handled as a load-use stall instead.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] addr,
    input logic       used,
    input logic [4:0] e_rd,
    input logic       e_we,
    input logic       e_load,
    input logic [4:0] l_rd,
    input logic       l_we,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    logic [1:0] sel;
    sel = NO_HAZARD;
    if (used && addr != 5'd0) begin
      if (e_we && !e_load && e_rd == addr)
        sel = FROM_EXE;
      else if (l_we && l_rd == addr)
        sel = FROM_LS;
      else if (w_we && w_rd == addr)
        sel = FROM_WB;
    end
    return sel;
  endfunction

  // Operand forwarding selects, forced to NO_HAZARD while in reset
  always_comb begin
    fwd_rs1_sel = NO_HAZARD;
    fwd_rs2_sel = NO_HAZARD;
    if (rst_n) begin
      fwd_rs1_sel = fwd_select(id_rs1_addr, id_rs1_used, exe_rd_addr, exe_rd_we,
                               exe_is_load, ls_rd_addr, ls_rd_we, wb_rd_addr, wb_rd_we);
      fwd_rs2_sel = fwd_select(id_rs2_addr, id_rs2_used, exe_rd_addr, exe_rd_we,
                               exe_is_load, ls_rd_addr, ls_rd_we, wb_rd_addr, wb_rd_we);
    end
  end

  // Load in EXE whose destination is read by the instruction in ID
  always_comb begin
    load_use = exe_is_load && exe_rd_we && (exe_rd_addr != 5'd0) &&
               ((id_rs1_used && id_rs1_addr == exe_rd_addr) ||
                (id_rs2_used && id_rs2_addr == exe_rd_addr));
  end

  // Mealy control outputs and next-state selection, highest priority first
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_exe    = 1'b0;
    stall_ls     = 1'b0;
    bubble_exe   = 1'b0;
    bubble_ls    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    set_err      = 1'b0;
    next_state   = state;
    next_wait    = wait_cnt;
    if (!rst_n) begin
      next_state = RUN;
      next_wait  = '0;
    end else if (mem_busy) begin
      // whole pipe freezes; the multi-cycle wait does not advance
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_ls  = 1'b1;
    end else if (state == MC_WAIT) begin
      if (exe_mc_done) begin
        next_state = RUN;
        next_wait  = '0;
      end else if (wait_cnt == WAIT_LIMIT) begin
        // give up on the unit and let the pipe move again
        set_err    = 1'b1;
        next_state = RUN;
        next_wait  = '0;
      end else begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_exe = 1'b1;
        bubble_ls = 1'b1;
        next_wait = wait_cnt + WAIT_W'(1);
      end
    end else if (exe_br_taken || exe_is_jump) begin
      // the dependent instruction in ID is killed, so a load-use stall is moot
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (exe_mc_start && !exe_mc_done) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_exe  = 1'b1;
      bubble_ls  = 1'b1;
      next_state = MC_WAIT;
      next_wait  = WAIT_W'(1);
    end else if (load_use) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      bubble_exe = 1'b1;
    end
  end

  // State, wait counter, sticky timeout flag and stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wait_cnt       <= '0;
      mc_timeout_err <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (set_err)
        mc_timeout_err <= 1'b1;
      if (stall_if)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, exe_rd_addr, ls_rd_addr, wb_rd_addr;
  logic        id_rs1_used, id_rs2_used, exe_rd_we, exe_is_load, ls_rd_we, wb_rd_we;
  logic        exe_br_taken, exe_is_jump, exe_mc_start, exe_mc_done, mem_busy;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        stall_if, stall_id, stall_exe, stall_ls;
  logic        bubble_exe, bubble_ls, flush_if_id, flush_id_exe, mc_timeout_err;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // model state: waiting on a multi-cycle unit, cycles waited so far
  bit          m_in_mc;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_cnt;

  hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_rd_addr(exe_rd_addr), .exe_rd_we(exe_rd_we), .exe_is_load(exe_is_load),
    .ls_rd_addr(ls_rd_addr), .ls_rd_we(ls_rd_we),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .exe_br_taken(exe_br_taken), .exe_is_jump(exe_is_jump),
    .exe_mc_start(exe_mc_start), .exe_mc_done(exe_mc_done), .mem_busy(mem_busy),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_exe(stall_exe), .stall_ls(stall_ls),
    .bubble_exe(bubble_exe), .bubble_ls(bubble_ls),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .mc_timeout_err(mc_timeout_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] a, input logic u);
    if (!u || a == 0) return 2'd0;
    if (exe_rd_we && !exe_is_load && exe_rd_addr == a) return 2'd1;
    if (ls_rd_we && ls_rd_addr == a) return 2'd2;
    if (wb_rd_we && wb_rd_addr == a) return 2'd3;
    return 2'd0;
  endfunction

  // Predict this cycle's outputs from the rules, compare, then advance the model
  task automatic eval_and_check();
    bit s_if, s_id, s_exe, s_ls, b_exe, b_ls, f_ifid, f_idexe, lu, set_err;
    logic [7:0] got_ctl, exp_ctl;
    s_if = 0; s_id = 0; s_exe = 0; s_ls = 0; b_exe = 0; b_ls = 0;
    f_ifid = 0; f_idexe = 0; set_err = 0;
    got_ctl = {stall_if, stall_id, stall_exe, stall_ls, bubble_exe, bubble_ls, flush_if_id, flush_id_exe};
    if (!rst_n) begin
      m_in_mc = 0; m_waited = 0; m_err = 0; m_cnt = 0;
      check("rst_ctl", {56'd0, got_ctl}, 64'd0);
      check("rst_fwd", {60'd0, fwd_rs1_sel, fwd_rs2_sel}, 64'd0);
      check("rst_err", {63'd0, mc_timeout_err}, 64'd0);
      check("rst_cnt", {32'd0, stall_cnt}, 64'd0);
    end else begin
      lu = exe_is_load && exe_rd_we && exe_rd_addr != 0 &&
           ((id_rs1_used && id_rs1_addr == exe_rd_addr) ||
            (id_rs2_used && id_rs2_addr == exe_rd_addr));
      if (mem_busy) begin
        s_if = 1; s_id = 1; s_exe = 1; s_ls = 1;
      end else if (m_in_mc) begin
        if (exe_mc_done) begin
          m_in_mc = 0; m_waited = 0;
        end else if (m_waited >= TO) begin
          set_err = 1; m_in_mc = 0; m_waited = 0;
        end else begin
          s_if = 1; s_id = 1; s_exe = 1; b_ls = 1; m_waited++;
        end
      end else if (exe_br_taken || exe_is_jump) begin
        f_ifid = 1; f_idexe = 1;
      end else if (exe_mc_start && !exe_mc_done) begin
        s_if = 1; s_id = 1; s_exe = 1; b_ls = 1; m_in_mc = 1; m_waited = 1;
      end else if (lu) begin
        s_if = 1; s_id = 1; b_exe = 1;
      end
      exp_ctl = {s_if, s_id, s_exe, s_ls, b_exe, b_ls, f_ifid, f_idexe};
      check("ctl", {56'd0, got_ctl}, {56'd0, exp_ctl});
      check("fwd_rs1", {62'd0, fwd_rs1_sel}, {62'd0, ref_fwd(id_rs1_addr, id_rs1_used)});
      check("fwd_rs2", {62'd0, fwd_rs2_sel}, {62'd0, ref_fwd(id_rs2_addr, id_rs2_used)});
      check("err", {63'd0, mc_timeout_err}, {63'd0, m_err});
      check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
      if (set_err) m_err = 1;
      if (s_if) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    exe_rd_addr = 0; exe_rd_we = 0; exe_is_load = 0;
    ls_rd_addr = 0; ls_rd_we = 0; wb_rd_addr = 0; wb_rd_we = 0;
    exe_br_taken = 0; exe_is_jump = 0; exe_mc_start = 0; exe_mc_done = 0; mem_busy = 0;
  endtask

  task automatic randomize_inputs();
    id_rs1_addr = 5'($urandom_range(0, 3));
    id_rs2_addr = 5'($urandom_range(0, 3));
    exe_rd_addr = 5'($urandom_range(0, 3));
    ls_rd_addr  = 5'($urandom_range(0, 3));
    wb_rd_addr  = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom_range(0, 3) != 0);
    id_rs2_used = 1'($urandom_range(0, 3) != 0);
    exe_rd_we   = 1'($urandom_range(0, 1));
    ls_rd_we    = 1'($urandom_range(0, 1));
    wb_rd_we    = 1'($urandom_range(0, 1));
    exe_is_load = 1'($urandom_range(0, 3) == 0);
    exe_br_taken = 1'($urandom_range(0, 9) == 0);
    exe_is_jump  = 1'($urandom_range(0, 19) == 0);
    exe_mc_start = (exe_br_taken || exe_is_jump) ? 1'b0 : 1'($urandom_range(0, 11) == 0);
    exe_mc_done  = 1'($urandom_range(0, 9) < 3);
    mem_busy     = 1'($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    randomize_inputs();
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    idle();

    // forwarding priority and x0
    id_rs1_addr = 5; id_rs1_used = 1;
    exe_rd_addr = 5; exe_rd_we = 1; ls_rd_addr = 5; ls_rd_we = 1; wb_rd_addr = 5; wb_rd_we = 1;
    #1 check("fwd_exe_direct", {62'd0, fwd_rs1_sel}, 64'd1);
    cycle();
    id_rs1_addr = 0;
    #1 check("fwd_x0_direct", {62'd0, fwd_rs1_sel}, 64'd0);
    cycle();

    // load-use then resolve through LS
    idle();
    exe_rd_addr = 7; exe_rd_we = 1; exe_is_load = 1; id_rs2_addr = 7; id_rs2_used = 1;
    #1 check("lu_stall_direct", {62'd0, stall_if, bubble_exe}, 64'd3);
    cycle();
    exe_is_load = 0; exe_rd_we = 0; ls_rd_addr = 7; ls_rd_we = 1;
    #1 check("lu_fwd_ls_direct", {62'd0, fwd_rs2_sel}, 64'd2);
    check("lu_cnt_direct", {32'd0, stall_cnt}, 64'd1);
    cycle();

    // multi-cycle op: done low for 3 waits, then high
    idle();
    exe_mc_start = 1;
    cycle();
    exe_mc_start = 0;
    repeat (3) cycle();
    exe_mc_done = 1;
    cycle();
    exe_mc_done = 0;
    #1 check("mc_cnt_direct", {32'd0, stall_cnt}, 64'd5);
    cycle();

    // branch beats load-use
    exe_br_taken = 1; exe_rd_addr = 3; exe_rd_we = 1; exe_is_load = 1; id_rs1_addr = 3; id_rs1_used = 1;
    cycle();
    idle();

    // timeout with a mem_busy freeze in the middle
    exe_mc_start = 1;
    cycle();
    exe_mc_start = 0;
    cycle();
    mem_busy = 1;
    repeat (2) cycle();
    mem_busy = 0;
    repeat (TO) cycle();
    #1 check("timeout_err_direct", {63'd0, mc_timeout_err}, 64'd1);
    repeat (2) cycle();

    // async reset in the middle of a wait
    exe_mc_start = 1;
    cycle();
    exe_mc_start = 0;
    cycle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 eval_and_check();
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
